// File: rtl/taylor_pkg.sv
// Shared FP constants, FSM encoding and operand classification for the exp(ln(x)/n) stage.
// Denormals classify as zero throughout, matching the flush behaviour of the FP primitives.
package taylor_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;
  localparam logic [31:0] FP_PINF = 32'h7f80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Exact single-precision value of integer k, used as the series divisor for term k.
  localparam logic [31:0] K_FLOAT [16] = '{
    32'h0000_0000, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0000,
    32'h4080_0000, 32'h40a0_0000, 32'h40c0_0000, 32'h40e0_0000,
    32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
    32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000
  };

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_MULDIV = 3'd2,
    S_ACC    = 3'd3,
    S_FIN    = 3'd4,
    S_SPEC   = 3'd5
  } state_t;

  function automatic logic is_zero(input logic [7:0] e);
    return (e == 8'h00);
  endfunction

  function automatic logic is_inf(input logic [7:0] e, input logic [22:0] m);
    return (e == 8'hff) && (m == 23'h0);
  endfunction

  function automatic logic is_nan(input logic [7:0] e, input logic [22:0] m);
    return (e == 8'hff) && (m != 23'h0);
  endfunction

  // Round-to-nearest-even on a mantissa with the hidden bit at [23], then pack.
  // Overflow saturates to infinity, underflow flushes to signed zero.
  function automatic logic [31:0] fp_round_pack(input logic s, input logic signed [9:0] e,
                                                input logic [23:0] m, input logic g,
                                                input logic st);
    logic [24:0]       mr;
    logic signed [9:0] er;
    mr = {1'b0, m} + ((g && (st || m[0])) ? 25'd1 : 25'd0);
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = e + 10'sd1;
    end
    if (er >= 10'sd255) return {s, 8'hff, 23'h0};
    if (er <= 10'sd0)   return {s, 31'h0};
    return {s, er[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/chia.sv
// Combinational IEEE754 single divider a/b, round-to-nearest-even, denormals flushed to zero.
module chia
  import taylor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic              s;
  logic [49:0]       num;
  logic [49:0]       den;
  logic [26:0]       q;
  logic [49:0]       r;
  logic              rem_nz;
  logic signed [9:0] e;

  always_comb begin
    s      = a[31] ^ b[31];
    num    = {1'b1, a[22:0], 26'h0};
    den    = {26'h0, 1'b1, b[22:0]};
    // Mantissa ratio lies in (0.5, 2), so the quotient fits in 27 bits.
    q      = 27'(num / den);
    r      = num % den;
    rem_nz = (r != 50'h0);
    e      = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

    if (is_nan(a[30:23], a[22:0]) || is_nan(b[30:23], b[22:0]) ||
        (is_zero(a[30:23]) && is_zero(b[30:23])) ||
        (is_inf(a[30:23], a[22:0]) && is_inf(b[30:23], b[22:0]))) begin
      y = FP_QNAN;
    end else if (is_inf(a[30:23], a[22:0]) || is_zero(b[30:23])) begin
      y = {s, FP_PINF[30:0]};
    end else if (is_zero(a[30:23]) || is_inf(b[30:23], b[22:0])) begin
      y = {s, 31'h0};
    end else if (q[26]) begin
      y = fp_round_pack(s, e, q[26:3], q[2], q[1] | q[0] | rem_nz);
    end else begin
      y = fp_round_pack(s, e - 10'sd1, q[25:2], q[1], q[0] | rem_nz);
    end
  end

endmodule

// File: rtl/cong_tru.sv
// Combinational IEEE754 single adder/subtractor: y = a + b (check_pt=0) or a - b (check_pt=1).
module cong_tru
  import taylor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        check_pt,
  output logic [31:0] y
);

  logic [31:0]       bb;
  logic [31:0]       big;
  logic [31:0]       sml;
  logic              sub;
  logic [7:0]        d;
  logic [49:0]       m_big;
  logic [49:0]       m_sml;
  logic [49:0]       m_sh;
  logic              lost;
  logic [49:0]       sum;
  logic [5:0]        lz;
  logic              found;
  logic [49:0]       norm;
  logic signed [9:0] e;

  always_comb begin
    bb = {b[31] ^ check_pt, b[30:0]};
    if (a[30:0] >= bb[30:0]) begin
      big = a;
      sml = bb;
    end else begin
      big = bb;
      sml = a;
    end
    sub   = big[31] ^ sml[31];
    d     = big[30:23] - sml[30:23];
    m_big = {2'b01, big[22:0], 25'h0};
    m_sml = {2'b01, sml[22:0], 25'h0};

    // Bits shifted out of the smaller operand are jammed into its LSB as sticky.
    if (d >= 8'd50) begin
      m_sh = 50'h0;
      lost = 1'b1;
    end else begin
      m_sh = m_sml >> d;
      lost = |(m_sml << (6'd50 - d[5:0]));
    end
    sum = sub ? (m_big - (m_sh | {49'h0, lost})) : (m_big + (m_sh | {49'h0, lost}));

    lz    = 6'd0;
    found = 1'b0;
    for (int i = 49; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 6'(49 - i);
        found = 1'b1;
      end
    end
    norm = sum << lz;
    e    = $signed({2'b00, big[30:23]}) + 10'sd1 - $signed({4'h0, lz});

    if (is_nan(a[30:23], a[22:0]) || is_nan(bb[30:23], bb[22:0]) ||
        (is_inf(a[30:23], a[22:0]) && is_inf(bb[30:23], bb[22:0]) && (a[31] != bb[31]))) begin
      y = FP_QNAN;
    end else if (is_inf(a[30:23], a[22:0])) begin
      y = a;
    end else if (is_inf(bb[30:23], bb[22:0])) begin
      y = bb;
    end else if (is_zero(a[30:23]) && is_zero(bb[30:23])) begin
      y = {a[31] & bb[31], 31'h0};
    end else if (is_zero(a[30:23])) begin
      y = bb;
    end else if (is_zero(bb[30:23])) begin
      y = a;
    end else if (sum == 50'h0) begin
      y = FP_ZERO;
    end else begin
      y = fp_round_pack(big[31], e, norm[49:26], norm[25], |norm[24:0]);
    end
  end

endmodule

// File: rtl/nhan.sv
// Combinational IEEE754 single multiplier, round-to-nearest-even, denormals flushed to zero.
module nhan
  import taylor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic              s;
  logic [47:0]       prod;
  logic signed [9:0] e;

  always_comb begin
    s    = a[31] ^ b[31];
    prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;

    if (is_nan(a[30:23], a[22:0]) || is_nan(b[30:23], b[22:0]) ||
        (is_inf(a[30:23], a[22:0]) && is_zero(b[30:23])) ||
        (is_inf(b[30:23], b[22:0]) && is_zero(a[30:23]))) begin
      y = FP_QNAN;
    end else if (is_inf(a[30:23], a[22:0]) || is_inf(b[30:23], b[22:0])) begin
      y = {s, FP_PINF[30:0]};
    end else if (is_zero(a[30:23]) || is_zero(b[30:23])) begin
      y = {s, 31'h0};
    end else if (prod[47]) begin
      y = fp_round_pack(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
    end else begin
      y = fp_round_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
    end
  end

endmodule

// File: rtl/taylor_exp_seq_step.sv
// Series term path: chia(nhan(term, y), k). In prep mode the same divider computes ln_in/n_root,
// so one divider serves both the y = ln/n setup and every term update.
module taylor_exp_seq_step
  import taylor_pkg::*;
(
  input  logic        prep,
  input  logic [31:0] term,
  input  logic [31:0] y_val,
  input  logic [31:0] k_div,
  input  logic [31:0] ln_val,
  input  logic [31:0] n_val,
  output logic [31:0] step_out
);

  logic [31:0] prod;
  logic [31:0] num;
  logic [31:0] den;

  nhan u_nhan (
    .a (term),
    .b (y_val),
    .y (prod)
  );

  assign num = prep ? ln_val : prod;
  assign den = prep ? n_val  : k_div;

  chia u_chia (
    .a (num),
    .b (den),
    .y (step_out)
  );

endmodule

// File: rtl/taylor_exp_seq.sv
// Sequential exp(ln_in/n_root) by a TERMS-term Maclaurin series on one shared mul/div/add set.
//   state  | meaning
//   IDLE   | waiting for start; operands latched and classified on accept
//   PREP   | y = ln/n, term = sum = 1.0, k = 1
//   MULDIV | term = term*y/k
//   ACC    | sum += term; last term goes to FIN with result and done
//   FIN    | done cycle of a series run
//   SPEC   | done cycle of a special-operand shortcut
module taylor_exp_seq
  import taylor_pkg::*;
#(
  parameter int TERMS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ln_in,
  input  logic [31:0] n_root,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state_q, state_d;
  logic [31:0] ln_q, ln_d;
  logic [31:0] n_q, n_d;
  logic [31:0] y_q, y_d;
  logic [31:0] term_q, term_d;
  logic [31:0] sum_q, sum_d;
  logic [3:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic [31:0] step_out;
  logic [31:0] sum_add;
  logic        spec_hit;
  logic [31:0] spec_val;

  taylor_exp_seq_step u_step (
    .prep     (state_q == S_PREP),
    .term     (term_q),
    .y_val    (y_q),
    .k_div    (K_FLOAT[k_q]),
    .ln_val   (ln_q),
    .n_val    (n_q),
    .step_out (step_out)
  );

  cong_tru u_add (
    .a        (sum_q),
    .b        (term_q),
    .check_pt (1'b0),
    .y        (sum_add)
  );

  // Special operands in priority order; anything else goes through the series.
  always_comb begin
    spec_hit = 1'b1;
    if (is_zero(n_root[30:23]) || is_nan(n_root[30:23], n_root[22:0]) ||
        is_nan(ln_in[30:23], ln_in[22:0])) begin
      spec_val = FP_QNAN;
    end else if (is_inf(ln_in[30:23], ln_in[22:0])) begin
      spec_val = ln_in[31] ? FP_ZERO : FP_PINF;
    end else if (is_zero(ln_in[30:23])) begin
      spec_val = FP_ONE;
    end else begin
      spec_val = FP_ZERO;
      spec_hit = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ln_d     = ln_q;
    n_d      = n_q;
    y_d      = y_q;
    term_d   = term_q;
    sum_d    = sum_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ln_d   = ln_in;
          n_d    = n_root;
          busy_d = 1'b1;
          if (spec_hit) begin
            result_d = spec_val;
            done_d   = 1'b1;
            state_d  = S_SPEC;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        y_d     = step_out;
        term_d  = FP_ONE;
        sum_d   = FP_ONE;
        k_d     = 4'd1;
        state_d = S_MULDIV;
      end
      S_MULDIV: begin
        term_d  = step_out;
        state_d = S_ACC;
      end
      S_ACC: begin
        sum_d = sum_add;
        if (k_q == 4'(TERMS)) begin
          result_d = sum_add;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_MULDIV;
        end
      end
      S_FIN, S_SPEC: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ln_q     <= 32'h0;
      n_q      <= 32'h0;
      y_q      <= 32'h0;
      term_q   <= 32'h0;
      sum_q    <= 32'h0;
      k_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      ln_q     <= ln_d;
      n_q      <= n_d;
      y_q      <= y_d;
      term_q   <= term_d;
      sum_q    <= sum_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_taylor_exp_seq.sv
// Directed bench for taylor_exp_seq: series results, latency, specials, start/reset corner cases.
module tb_taylor_exp_seq;

  localparam logic [31:0] LN4  = 32'h3fb1_7218;
  localparam logic [31:0] LNQ  = 32'hbfb1_7218;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] MTWO = 32'hc000_0000;
  localparam logic [31:0] ONE  = 32'h3f80_0000;
  localparam logic [31:0] HALF = 32'h3f00_0000;
  localparam logic [31:0] E_F  = 32'h402d_f854;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ln_in = 32'h0;
  logic [31:0] n_root = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass = 0;

  taylor_exp_seq #(.TERMS(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ln_in  (ln_in),
    .n_root (n_root),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                           input int tol);
    int diff;
    diff = int'(obs) - int'(expv);
    n_checks++;
    assert (!$isunknown(obs) && diff <= tol && diff >= -tol) n_pass++;
    else $error("FAIL %s: observed %h expected %h +/-%0d ulp", tag, obs, expv, tol);
  endtask

  // One start pulse; returns result at done, cycle of done (0 on timeout) and busy-high cycles.
  task automatic run_op(input logic [31:0] ln, input logic [31:0] n, output logic [31:0] res,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    ln_in  = ln;
    n_root = n;
    start  = 1'b1;
    lat      = 0;
    busy_cyc = 0;
    res      = 32'hxxxx_xxxx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  logic [31:0] res;
  int          lat;
  int          bcyc;
  int          n_done;
  int          d1, d2, d3;
  logic        prev_done;
  logic        wide;

  logic [31:0] sp_ln  [7] = '{32'h7fc0_0000, 32'hff80_0000, LN4, 32'h0000_0000,
                              32'h7f80_0000, 32'h0000_0001, 32'h8000_0000};
  logic [31:0] sp_n   [7] = '{TWO, TWO, 32'h0000_0000, TWO, TWO, TWO, 32'h0000_0000};
  logic [31:0] sp_exp [7] = '{32'h7fc0_0000, 32'h0000_0000, 32'h7fc0_0000, ONE,
                              32'h7f80_0000, ONE, 32'h7fc0_0000};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op(LN4, TWO, res, lat, bcyc);
    check("sqrt4_lat", 32'(lat), 32'd22);
    check_ulp("sqrt4_res", res, TWO, 4);
    check("sqrt4_busy", 32'(bcyc), 32'd22);
    @(negedge clk);
    check("sqrt4_done_pulse", {31'h0, done}, 32'h0);
    check("sqrt4_hold", result, res);

    run_op(LNQ, TWO, res, lat, bcyc);
    check("sqrtq_lat", 32'(lat), 32'd22);
    check_ulp("sqrtq_res", res, HALF, 4);
    check("sqrtq_busy", 32'(bcyc), 32'd22);

    run_op(ONE, ONE, res, lat, bcyc);
    check("e_lat", 32'(lat), 32'd22);
    check_ulp("e_res", res, E_F, 4);

    run_op(LN4, MTWO, res, lat, bcyc);
    check_ulp("negn_res", res, HALF, 4);

    for (int i = 0; i < 7; i++) begin
      run_op(sp_ln[i], sp_n[i], res, lat, bcyc);
      check($sformatf("spec%0d_lat", i), 32'(lat), 32'd1);
      check($sformatf("spec%0d_res", i), res, sp_exp[i]);
    end

    // Starts at cycles 5 and 10 carry a special operand; accepting either would show early.
    @(negedge clk);
    ln_in  = LN4;
    n_root = TWO;
    start  = 1'b1;
    n_done = 0;
    lat    = 0;
    res    = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 10);
      if (c == 5 || c == 10) begin
        ln_in  = 32'h0;
        n_root = ONE;
      end
      if (done) begin
        n_done++;
        lat = c;
        res = result;
      end
    end
    check("ign_dones", 32'(n_done), 32'd1);
    check("ign_lat", 32'(lat), 32'd22);
    check_ulp("ign_res", res, TWO, 4);
    check_ulp("ign_hold", result, TWO, 4);

    @(negedge clk);
    ln_in  = LNQ;
    n_root = TWO;
    start  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(LN4, TWO, res, lat, bcyc);
    check("post_rst_lat", 32'(lat), 32'd22);
    check_ulp("post_rst_res", res, TWO, 4);

    @(negedge clk);
    ln_in  = LN4;
    n_root = TWO;
    start  = 1'b1;
    n_done = 0;
    d1 = 0;
    d2 = 0;
    d3 = 0;
    prev_done = 1'b0;
    wide = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (prev_done) wide = 1'b1;
        if (n_done == 1) d1 = c;
        if (n_done == 2) d2 = c;
        if (n_done == 3) d3 = c;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_dones", 32'(n_done), 32'd3);
    check("b2b_first", 32'(d1), 32'd22);
    check("b2b_period1", 32'(d2 - d1), 32'd23);
    check("b2b_period2", 32'(d3 - d2), 32'd23);
    check("b2b_width", {31'h0, wide}, 32'h0);
    check_ulp("b2b_res", result, TWO, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
